// File: rtl/io_input_port_if.sv
// CPU-side MMIO bus of the switch/LED input port.
// The CPU is the master; the port decodes word offsets and returns read data.
interface io_input_port_if;
  logic [7:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output io_addr,
    output io_we,
    output io_re,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_addr,
    input  io_we,
    input  io_re,
    input  io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/io_input_port.sv
// Debounced push-button capture of switch data into a one-entry input register,
// plus an LED output register, all exposed to the CPU through a small MMIO map.
module io_input_port #(
  parameter int IN_W      = 5,
  parameter int OUT_W     = 5,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [IN_W-1:0]  in,
  output logic             ready,
  io_input_port_if.slave   io,
  output logic [OUT_W-1:0] out0
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  localparam logic [7:0] ADDR_OUT0  = 8'h00;
  localparam logic [7:0] ADDR_OUT_R = 8'h04;
  localparam logic [7:0] ADDR_STAT  = 8'h08;
  localparam logic [7:0] ADDR_IN    = 8'h0C;

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic [CW-1:0] cnt;
  logic [IN_W-1:0] in_reg;
  logic          in_full;
  logic          overrun;

  logic differ;
  logic capture;
  logic rd_in;
  logic wr_out;
  logic wr_clr;

  assign differ  = sync2 ^ filt;
  // Only a rising acceptance of the button is a capture; the falling one just re-arms.
  assign capture = differ && (cnt == CNT_MAX) && !filt;

  assign rd_in  = io.io_re && (io.io_addr == ADDR_IN);
  assign wr_out = io.io_we && (io.io_addr == ADDR_OUT0);
  assign wr_clr = io.io_we && (io.io_addr == ADDR_STAT) && io.io_wdata[1];

  assign ready = ~in_full;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain sync1 into sync2 in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      filt  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= valid;
      sync2 <= sync1;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        filt <= ~filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: in_reg is reset even though it is data, because a reset must drop any
  // held switch value rather than leave it readable afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_reg  <= '0;
      in_full <= 1'b0;
      overrun <= 1'b0;
      out0    <= '0;
    end else begin
      if (wr_out) begin
        out0 <= io.io_wdata[OUT_W-1:0];
      end

      // Clear is written before the capture path so a same-cycle set wins.
      if (wr_clr) begin
        overrun <= 1'b0;
      end

      // A read of the input register in the capture cycle frees the slot, so
      // the new value is taken and the register stays full without overrun.
      if (capture) begin
        if (!in_full || rd_in) begin
          in_reg  <= in;
          in_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_in) begin
        in_full <= 1'b0;
      end
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    io.io_rdata = '0;
    if (io.io_re) begin
      case (io.io_addr)
        ADDR_OUT_R: io.io_rdata = 32'(out0);
        ADDR_STAT:  io.io_rdata = {30'b0, overrun, in_full};
        ADDR_IN:    io.io_rdata = 32'(in_reg);
        default:    io.io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_port.sv
// Self-checking bench for io_input_port: directed scenarios followed by random
// button/bus traffic, compared against a windowed behavioural model.
module tb_io_input_port;
  localparam int IN_W = 5;
  localparam int OUT_W = 5;
  localparam int DB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic [IN_W-1:0]  sw;
  logic             ready;
  logic [OUT_W-1:0] out0;

  io_input_port_if bus ();

  io_input_port #(.IN_W(IN_W), .OUT_W(OUT_W), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .in    (sw),
    .ready (ready),
    .io    (bus),
    .out0  (out0)
  );

  always #5 clk = ~clk;

  int n_pass;
  int n_chk;

  // Model: accepted level flips once DB consecutive synchronised samples,
  // all observed after the previous flip, disagree with the accepted level.
  bit          vh [0:4095];
  int          k;
  int          last_tog;
  bit          m_filt;
  bit          m_full;
  bit          m_over;
  logic [4:0]  m_in;
  logic [4:0]  m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    k = 0;
    last_tog = 0;
    m_filt = 1'b0;
    m_full = 1'b0;
    m_over = 1'b0;
    m_in = '0;
    m_out = '0;
  endtask

  function automatic logic [31:0] exp_rd();
    if (!bus.io_re) return 32'h0;
    case (bus.io_addr)
      8'h04:   return {27'b0, m_out};
      8'h08:   return {30'b0, m_over, m_full};
      8'h0C:   return {27'b0, m_in};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    int run;
    bit stop;
    bit flip;
    bit cap;
    bit rd_in;
    bit full_old;
    if (k < 4095) k++;
    vh[k] = valid;
    run = 0;
    stop = 1'b0;
    for (int i = k - 2; i >= 1 && i > last_tog - 2 && !stop; i--) begin
      if (vh[i] != m_filt) run++;
      else stop = 1'b1;
    end
    flip = (run >= DB);
    cap = flip && !m_filt;
    if (flip) begin
      m_filt = !m_filt;
      last_tog = k;
    end
    rd_in = bus.io_re && (bus.io_addr == 8'h0C);
    full_old = m_full;
    if (bus.io_we && bus.io_addr == 8'h00) m_out = bus.io_wdata[4:0];
    if (bus.io_we && bus.io_addr == 8'h08 && bus.io_wdata[1]) m_over = 1'b0;
    if (cap) begin
      if (!full_old || rd_in) begin
        m_in = sw;
        m_full = 1'b1;
      end else begin
        m_over = 1'b1;
      end
    end else if (rd_in) begin
      m_full = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, check read data, clock, check state.
  task automatic cyc(input logic v, input logic [4:0] d, input logic re, input logic we,
                     input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rd);
    valid = v;
    sw = d;
    bus.io_re = re;
    bus.io_we = we;
    bus.io_addr = a;
    bus.io_wdata = wd;
    #1;
    rd = bus.io_rdata;
    check("rdata", rd, exp_rd());
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ready", 32'(ready), 32'(!m_full));
    check("out0", 32'(out0), {27'b0, m_out});
  endtask

  task automatic tick(input logic v, input logic [4:0] d);
    logic [31:0] rd;
    cyc(v, d, 1'b0, 1'b0, 8'h00, 32'h0, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    cyc(1'b0, 5'h0, 1'b1, 1'b0, a, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    cyc(1'b0, 5'h0, 1'b0, 1'b1, a, wd, rd);
  endtask

  task automatic press(input logic [4:0] d);
    repeat (8) tick(1'b1, d);
    repeat (8) tick(1'b0, d);
  endtask

  initial begin
    logic [31:0] rd;
    int runlen;
    logic v_r;
    logic [4:0] d_r;
    int op;

    n_pass = 0;
    n_chk = 0;
    rst = 1'b0;
    valid = 1'b0;
    sw = '0;
    bus.io_re = 1'b0;
    bus.io_we = 1'b0;
    bus.io_addr = '0;
    bus.io_wdata = '0;
    model_reset();

    // Reset state
    #2;
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_out0", 32'(out0), 32'h0);
    bus.io_re = 1'b1;
    bus.io_addr = 8'h08;
    #1;
    check("rst_stat", bus.io_rdata, 32'h0);
    bus.io_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Clean press: capture exactly at the sixth edge
    repeat (5) tick(1'b1, 5'h16);
    check("press_pre6_ready", 32'(ready), 32'h1);
    tick(1'b1, 5'h16);
    check("press_edge6_ready", 32'(ready), 32'h0);
    repeat (8) tick(1'b0, 5'h16);
    rd_chk("clean_rd_in", 8'h0C, 32'h16);
    check("clean_ready_after", 32'(ready), 32'h1);

    // Bounce: never stable long enough
    repeat (5) begin
      repeat (3) tick(1'b1, 5'h09);
      repeat (2) tick(1'b0, 5'h09);
    end
    repeat (10) tick(1'b0, 5'h09);
    check("bounce_ready", 32'(ready), 32'h1);
    rd_chk("bounce_stat", 8'h08, 32'h0);

    // Overrun
    press(5'h01);
    press(5'h02);
    rd_chk("ovr_stat", 8'h08, 32'h3);
    wr(8'h08, 32'h2);
    rd_chk("ovr_stat_clr", 8'h08, 32'h1);
    rd_chk("ovr_rd_in", 8'h0C, 32'h1);

    // Collision: read of the input register in the capture cycle
    press(5'h07);
    repeat (5) tick(1'b1, 5'h1F);
    cyc(1'b1, 5'h1F, 1'b1, 1'b0, 8'h0C, 32'h0, rd);
    check("coll_rd_old", rd, 32'h07);
    check("coll_ready", 32'(ready), 32'h0);
    repeat (2) tick(1'b1, 5'h1F);
    repeat (8) tick(1'b0, 5'h1F);
    rd_chk("coll_stat", 8'h08, 32'h1);
    rd_chk("coll_rd_new", 8'h0C, 32'h1F);

    // Output register and unmapped addresses
    wr(8'h00, 32'hFFFF_FFE5);
    check("out0_wr", 32'(out0), 32'h05);
    rd_chk("out0_rd", 8'h04, 32'h05);
    rd_chk("unmapped_rd", 8'h10, 32'h0);
    wr(8'h10, 32'h1F);
    check("unmapped_wr", 32'(out0), 32'h05);

    // Simultaneous read and clear-write of the status register
    press(5'h03);
    press(5'h03);
    cyc(1'b0, 5'h0, 1'b1, 1'b1, 8'h08, 32'h2, rd);
    check("rw_stat_old", rd, 32'h3);
    rd_chk("rw_stat_new", 8'h08, 32'h1);
    rd_chk("rw_rd_in", 8'h0C, 32'h3);

    // Async reset while full and mid-debounce
    press(5'h0A);
    repeat (4) tick(1'b1, 5'h04);
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_ready", 32'(ready), 32'h1);
    check("arst_out0", 32'(out0), 32'h0);
    bus.io_re = 1'b1;
    bus.io_addr = 8'h0C;
    #1;
    check("arst_rd_in", bus.io_rdata, 32'h0);
    bus.io_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) tick(1'b1, 5'h04);
    check("arst_redebounce_ready", 32'(ready), 32'h1);
    tick(1'b1, 5'h04);
    check("arst_capture_ready", 32'(ready), 32'h0);
    repeat (8) tick(1'b0, 5'h04);
    rd_chk("arst_rd_new", 8'h0C, 32'h04);

    // Random button levels and bus traffic against the model
    runlen = 0;
    v_r = 1'b0;
    d_r = '0;
    for (int c = 0; c < 600; c++) begin
      if (runlen == 0) begin
        runlen = int'($urandom_range(1, 9));
        v_r = 1'($urandom_range(0, 1));
        if (v_r) d_r = 5'($urandom_range(0, 31));
      end
      runlen--;
      op = int'($urandom_range(0, 9));
      case (op)
        0: cyc(v_r, d_r, 1'b1, 1'b0, 8'h04, 32'h0, rd);
        1: cyc(v_r, d_r, 1'b1, 1'b0, 8'h08, 32'h0, rd);
        2, 3: cyc(v_r, d_r, 1'b1, 1'b0, 8'h0C, 32'h0, rd);
        4: cyc(v_r, d_r, 1'b0, 1'b1, 8'h00, $urandom, rd);
        5: cyc(v_r, d_r, 1'($urandom_range(0, 1)), 1'b1, 8'h08, $urandom, rd);
        6: cyc(v_r, d_r, 1'b1, 1'b0, 8'h10, 32'h0, rd);
        7: cyc(v_r, d_r, 1'b0, 1'b1, 8'h14, $urandom, rd);
        default: cyc(v_r, d_r, 1'b0, 1'b0, 8'h00, 32'h0, rd);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
IO_INPUT_PORT -- requirements
Module: io_input_port

Interface
REQ-001 Parameter IN_W, default 5: switch data width.
REQ-002 Parameter OUT_W, default 5: LED output register width.
REQ-003 Parameter DB_CYCLES, default 4 (>=2): cycles `valid` must stay stable before a level change is accepted.
REQ-004 Port clk  input  1: single clock; all state on rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-low.
REQ-006 Port valid  input  1: board push-button, asynchronous and bouncy; a rising level means new input data.
REQ-007 Port in  input  IN_W: switch data; stable while `valid` is high.
REQ-008 Port ready  output  1: high when the input register is empty and can accept a new value.
REQ-009 Port io_addr  input  8: CPU MMIO word address offset.
REQ-010 Port io_we  input  1: CPU MMIO write strobe, one cycle per access.
REQ-011 Port io_re  input  1: CPU MMIO read strobe, one cycle per access.
REQ-012 Port io_wdata  input  32: CPU write data.
REQ-013 Port io_rdata  output  32: CPU read data, combinational.
REQ-014 Port out0  output  OUT_W: LED output register.

Function
REQ-015 The block SHALL pass `valid` through two synchronizer flops, sync1 then sync2.
REQ-016 The debounce counter SHALL increment each cycle that sync2 differs from the filtered level `filt`, and SHALL clear to 0 on any cycle where they are equal.
REQ-017 When the counter equals DB_CYCLES-1 and sync2 still differs from `filt`, the block SHALL toggle `filt` at that edge and clear the counter.
REQ-018 A 0->1 toggle of `filt` SHALL be a capture event, occurring at the (2+DB_CYCLES)th rising edge after `valid` goes high and stays high.
REQ-019 On a capture event with in_full=0, the block SHALL load in_reg from `in` sampled at that edge and SET in_full.
REQ-020 On a capture event with in_full=1, the block SHALL leave in_reg unchanged and SET the sticky overrun flag.
REQ-021 `ready` SHALL equal ~in_full, driven directly from the register with no extra latency.
REQ-022 Register map; all other addresses read 0 and ignore writes:
- 0x00 W: out0 <= io_wdata[OUT_W-1:0]
- 0x04 R: {zero-ext, out0}
- 0x08 R: {30'b0, overrun, in_full}
- 0x08 W: io_wdata[1]=1 clears overrun
- 0x0C R: {zero-ext, in_reg}; clears in_full at that edge
REQ-023 io_rdata SHALL be 0 whenever io_re=0; reads other than 0x0C SHALL have no side effects.
REQ-024 When a read of 0x0C and a capture event occur in the same cycle, the CPU SHALL receive the old in_reg, in_reg SHALL load the new value, in_full SHALL remain 1, and overrun SHALL be unchanged.
REQ-025 When a 0x08 overrun-clear write and an overrun-setting capture occur in the same cycle, set SHALL win and overrun = 1.
REQ-026 io_we and io_re MAY be asserted together on different addresses, and each SHALL take effect independently.
REQ-027 A 1->0 toggle of `filt` SHALL have no effect beyond re-arming the next capture.
REQ-028 Bounces shorter than DB_CYCLES cycles SHALL produce no event.

Reset
REQ-029 While rst=0, the block SHALL immediately force: sync1, sync2, filt, counter, in_reg, in_full, overrun and out0 all 0; ready=1; io_rdata=0 when io_re=0.
REQ-030 An rst assertion mid-debounce SHALL discard the pending count, and after release `valid` must again be stable for a full DB_CYCLES.
REQ-031 An rst assertion with in_full=1 SHALL drop the held data.

Verification
REQ-032 Clean press: after reset release, in=5'b10110 and valid held high -> in_full and ready change exactly at edge 6 (DB_CYCLES=4); read 0x0C returns 32'h16, and ready=1 on the next cycle.
REQ-033 Bounce: valid pulses high 3 cycles, low 2 cycles, repeated 5 times, then stays low -> no capture; in_full=0, counter returns to 0.
REQ-034 Overrun: two clean presses (in=1, then in=2) with no read -> in_reg=1, read 0x08 = 32'h3; write 0x08 with 32'h2 -> read 0x08 = 32'h1.
REQ-035 Collision: capture of in=5'h1F in the same cycle as a read of 0x0C holding 5'h07 -> io_rdata=32'h07, in_reg=5'h1F, in_full=1, overrun=0.
REQ-036 Output/map: write 0x00 with 32'hFFFF_FFE5 -> out0=5'h05; read 0x04 returns 32'h05; read 0x10 returns 0; write 0x10 leaves out0 unchanged.
REQ-037 Async reset: assert rst low mid-cycle with in_full=1 and out0=5'h05 -> all outputs reset before the next clock edge and ready=1.
